raptor64_regfetch: RTL and testbench
====================================

Name: raptor64_regfetch

Overview:
- Register-fetch stage of the Raptor64 pipeline, the producer side of the execute-unit operand interface.
- Accepts a decoded 42-bit instruction, reads the 32x64 register file with bypass from execute and writeback, and builds the 64-bit immediate, including IMM-prefix extension.
- Presents xIR/a/b/imm in a registered execute bundle under a valid/ready handshake.
- Owns the register-file write port, driven from writeback.

Parameters:
- NREGS, 32, number of architectural registers; r0 reads as zero.
- DW, 64, datapath width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- d_valid  in  1  decode offers instruction
- d_ir  in  42  instruction: opcode [41:35], Ra [34:30], Rb [29:25], imm [24:0]
- d_ready  out  1  stage accepts instruction this cycle
- flush  in  1  squash held bundle and pending prefix
- x_valid  out  1  execute bundle valid
- x_ready  in  1  execute consumes bundle
- xIR  out  42  instruction to execute
- a  out  64  operand A
- b  out  64  operand B
- imm  out  64  extended immediate
- ex_fwd_en  in  1  execute result valid for bypass
- ex_fwd_rt  in  5  execute destination
- ex_fwd_res  in  64  execute result
- wb_en  in  1  writeback enable
- wb_rt  in  5  writeback destination
- wb_res  in  64  writeback data

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: x_valid=0, xIR=0, a=0, b=0, imm=0, prefix state=IDLE, prefix register=0. Register-file contents are not reset, except that r0 reads 0 at all times.
- Handshake:
  - d_ready = !x_valid | x_ready.
  - A transfer occurs when d_valid & d_ready.
  - x_valid rises the cycle after a transfer of a non-IMM instruction.
  - The bundle holds stable while x_valid & !x_ready.
  - x_valid drops after x_ready if no new transfer occurs.
- Latency: 1 cycle from d_ir transfer to bundle on outputs. Back-to-back transfers give full throughput.
- Operand select, evaluated at transfer, priority high to low:
  1. Ra==0 gives 0.
  2. ex_fwd_en & ex_fwd_rt==Ra gives ex_fwd_res.
  3. wb_en & wb_rt==Ra gives wb_res.
  4. Otherwise the register-file read.
  - Same rules apply for Rb/b.
  - The value is captured once and not refreshed while the bundle is stalled.
- Register file:
  - Written on wb_en at the clock edge; wb_rt==0 writes are ignored.
  - A read and write of the same register in one cycle returns wb_res via the bypass.
- Immediate:
  - IDLE: imm = sign-extend(d_ir[24:0]) to 64 bits.
  - PFX: imm = {{4{pfx[34]}}, pfx[34:0], d_ir[24:0]}.
- Prefix FSM (IMM opcode from the shared package):
  - IDLE to PFX on transfer of IMM: store d_ir[34:0]. No bundle is produced; x_valid is unaffected by the IMM itself.
  - PFX + IMM transfer: overwrite the prefix, stay in PFX.
  - PFX + non-IMM transfer: use the prefix, go to IDLE.
  - The prefix never expires by time; only consumption, flush or reset clear it.
- Flush:
  - Next cycle x_valid=0, FSM=IDLE.
  - Any transfer in the flush cycle is discarded.
  - Register-file writes in the flush cycle still occur.
- Simultaneous events:
  - Reset overrides flush; flush overrides transfer.
  - x_ready together with a new transfer replaces the bundle with no bubble.
- Hazards older than writeback are excluded by the pipeline; no interlock is generated here.

Decomposition:
- Package raptor64_pkg holds:
  - opcode constants (RR, ANDI, ORI, XORI, IMM, ...) and funct constants;
  - instruction field-position localparams (OPC_HI/LO, RA_HI/LO, RB_HI/LO, IMM_HI/LO);
  - the prefix-state enum.
- Sub-module raptor64_regfile: 32x64, two async read ports, one sync write port, r0 hardwired to zero.
- Bypass, immediate builder and handshake remain in the top module.

Test Plan:
- Reset then write r3=0x1234 via wb; transfer ORI Ra=3 imm=0x0000F -> next cycle x_valid=1, a=0x1234, imm=0xF.
- Transfer RR AND Ra=5 Rb=5 with ex_fwd_en rt=5 res=0xAAAA and wb_en rt=5 res=0x5555 in the same cycle -> a=b=0xAAAA (execute bypass wins).
- IMM with [34:0]=0x400000001 followed by XORI imm=0x1FFFFFF -> imm=0xF800_0000_03FF_FFFF. Only one bundle is produced; the next XORI uses a sign-extended imm.
- Hold x_ready=0 for 3 cycles with d_valid=1 -> d_ready=0 and bundle stable. A wb write to the held Ra during the stall does not change a.
- IMM accepted, then flush asserted, then ANDI imm=0x10 -> imm=0x10 (prefix cleared), x_valid low for the flush cycle.
- wb_en rt=0 res=0xFFFF, then read Ra=0 -> a=0. Also pull rst_ni low while x_valid=1 and FSM in PFX -> next cycle all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/raptor64_pkg.sv
// Shared Raptor64 definitions: opcodes, funct codes, instruction field
// positions and the immediate-prefix state encoding.
package raptor64_pkg;

    // Instruction field positions within the 42-bit decoded instruction
    localparam int OPC_HI = 41;
    localparam int OPC_LO = 35;
    localparam int RA_HI  = 34;
    localparam int RA_LO  = 30;
    localparam int RB_HI  = 29;
    localparam int RB_LO  = 25;
    localparam int IMM_HI = 24;
    localparam int IMM_LO = 0;

    localparam int IR_W   = 42;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;   // 25-bit inline immediate
    localparam int PFX_W  = RA_HI + 1;             // 35-bit prefix payload

    // Major opcodes
    localparam logic [6:0] OP_RR   = 7'h02;
    localparam logic [6:0] OP_ADDI = 7'h04;
    localparam logic [6:0] OP_ANDI = 7'h08;
    localparam logic [6:0] OP_ORI  = 7'h09;
    localparam logic [6:0] OP_XORI = 7'h0A;
    localparam logic [6:0] OP_IMM  = 7'h7C;

    // Register-register funct codes (low bits of the immediate field)
    localparam logic [6:0] FN_ADD = 7'h04;
    localparam logic [6:0] FN_SUB = 7'h05;
    localparam logic [6:0] FN_AND = 7'h08;
    localparam logic [6:0] FN_OR  = 7'h09;
    localparam logic [6:0] FN_XOR = 7'h0A;

    // Immediate-prefix tracking: IDLE, or holding an IMM payload for the next op
    typedef enum logic {
        PFX_IDLE = 1'b0,
        PFX_HELD = 1'b1
    } pfx_state_e;

endpackage

// File: rtl/raptor64_regfile.sv
// 32x64 architectural register file: two asynchronous read ports and one
// synchronous write port. r0 is hardwired to zero and never written.
module raptor64_regfile #(
    parameter int NREGS = 32,
    parameter int DW    = 64,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREGS];

    // Storage is intentionally not reset; writes to r0 are dropped
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/raptor64_regfetch.sv
// Raptor64 register-fetch stage: reads operands with execute/writeback
// bypass, builds the 64-bit immediate (with IMM-prefix extension) and hands
// a registered bundle to execute under a valid/ready handshake.
module raptor64_regfetch
    import raptor64_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int DW    = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          d_valid,
    input  logic [41:0]   d_ir,
    output logic          d_ready,
    input  logic          flush,
    output logic          x_valid,
    input  logic          x_ready,
    output logic [41:0]   xIR,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [DW-1:0] imm,
    input  logic          ex_fwd_en,
    input  logic [4:0]    ex_fwd_rt,
    input  logic [DW-1:0] ex_fwd_res,
    input  logic          wb_en,
    input  logic [4:0]    wb_rt,
    input  logic [DW-1:0] wb_res
);

    logic             x_valid_q, x_valid_d;
    logic [IR_W-1:0]  xir_q, xir_d;
    logic [DW-1:0]    a_q, a_d;
    logic [DW-1:0]    b_q, b_d;
    logic [DW-1:0]    imm_q, imm_d;
    pfx_state_e       state_q, state_d;
    logic [PFX_W-1:0] pfx_q, pfx_d;

    logic [4:0]       ra, rb;
    logic [DW-1:0]    rf_a, rf_b;
    logic             transfer, is_imm;

    // Zero register first, then youngest in-flight result, then writeback
    function automatic logic [DW-1:0] sel_operand(
        input logic [4:0]    r,
        input logic [DW-1:0] rf_val,
        input logic          ex_en,
        input logic [4:0]    ex_rt,
        input logic [DW-1:0] ex_res,
        input logic          w_en,
        input logic [4:0]    w_rt,
        input logic [DW-1:0] w_res
    );
        if (r == 5'd0)                   return '0;
        else if (ex_en && (ex_rt == r))  return ex_res;
        else if (w_en && (w_rt == r))    return w_res;
        else                             return rf_val;
    endfunction

    // A held prefix supplies the upper bits; otherwise sign-extend the field
    function automatic logic [DW-1:0] build_imm(
        input logic             held,
        input logic [PFX_W-1:0] pfx,
        input logic [IMM_W-1:0] field
    );
        if (held) return {{(DW-PFX_W-IMM_W){pfx[PFX_W-1]}}, pfx, field};
        else      return {{(DW-IMM_W){field[IMM_W-1]}}, field};
    endfunction

    assign ra       = d_ir[RA_HI:RA_LO];
    assign rb       = d_ir[RB_HI:RB_LO];
    assign d_ready  = !x_valid_q || x_ready;
    assign transfer = d_valid && d_ready;
    assign is_imm   = (d_ir[OPC_HI:OPC_LO] == OP_IMM);

    raptor64_regfile #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk_i     (clk_i),
        .we_i      (wb_en),
        .waddr_i   (wb_rt),
        .wdata_i   (wb_res),
        .raddr_a_i (ra),
        .rdata_a_o (rf_a),
        .raddr_b_i (rb),
        .rdata_b_o (rf_b)
    );

    // Next-state: flush beats transfer; IMM only updates the prefix
    always_comb begin
        x_valid_d = x_valid_q && !x_ready;
        xir_d     = xir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        state_d   = state_q;
        pfx_d     = pfx_q;
        if (flush) begin
            x_valid_d = 1'b0;
            state_d   = PFX_IDLE;
            pfx_d     = '0;
        end else if (transfer) begin
            if (is_imm) begin
                state_d = PFX_HELD;
                pfx_d   = d_ir[PFX_W-1:0];
            end else begin
                x_valid_d = 1'b1;
                xir_d     = d_ir;
                a_d       = sel_operand(ra, rf_a, ex_fwd_en, ex_fwd_rt, ex_fwd_res,
                                        wb_en, wb_rt, wb_res);
                b_d       = sel_operand(rb, rf_b, ex_fwd_en, ex_fwd_rt, ex_fwd_res,
                                        wb_en, wb_rt, wb_res);
                imm_d     = build_imm(state_q == PFX_HELD, pfx_q, d_ir[IMM_HI:IMM_LO]);
                state_d   = PFX_IDLE;
                pfx_d     = '0;
            end
        end
    end

    // Execute bundle and prefix registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_valid_q <= 1'b0;
            xir_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            state_q   <= PFX_IDLE;
            pfx_q     <= '0;
        end else begin
            x_valid_q <= x_valid_d;
            xir_q     <= xir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            state_q   <= state_d;
            pfx_q     <= pfx_d;
        end
    end

    assign x_valid = x_valid_q;
    assign xIR     = xir_q;
    assign a       = a_q;
    assign b       = b_q;
    assign imm     = imm_q;

endmodule

// File: tb/tb_raptor64_regfetch.sv
// Bench for raptor64_regfetch: directed scenarios plus random traffic, with
// a reference model feeding an expected-bundle queue and a separate monitor.
module tb_raptor64_regfetch;
    import raptor64_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni, d_valid, d_ready, flush, x_valid, x_ready;
    logic [41:0] d_ir, xIR;
    logic [63:0] a, b, imm;
    logic        ex_fwd_en, wb_en;
    logic [4:0]  ex_fwd_rt, wb_rt;
    logic [63:0] ex_fwd_res, wb_res;

    always #5 clk_i = ~clk_i;

    raptor64_regfetch dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_valid(d_valid), .d_ir(d_ir),
        .d_ready(d_ready), .flush(flush), .x_valid(x_valid), .x_ready(x_ready),
        .xIR(xIR), .a(a), .b(b), .imm(imm),
        .ex_fwd_en(ex_fwd_en), .ex_fwd_rt(ex_fwd_rt), .ex_fwd_res(ex_fwd_res),
        .wb_en(wb_en), .wb_rt(wb_rt), .wb_res(wb_res)
    );

    typedef struct packed {
        logic [41:0] ir;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
    } bund_t;

    int          total = 0;
    int          bad   = 0;
    bund_t       expq[$];
    logic [63:0] m_regs [32];
    bit          m_xvalid = 0;
    bit          m_pfx_v  = 0;
    bit          m_zero   = 1;
    logic [34:0] m_pfx    = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [41:0] mk(input logic [6:0] opc, input logic [4:0] ra,
                                       input logic [4:0] rb, input logic [24:0] i25);
        return {opc, ra, rb, i25};
    endfunction

    // Reference operand: zero register, then execute result, then writeback, then storage
    function automatic logic [63:0] ref_opnd(input logic [4:0] r);
        if (r == 0) return 64'd0;
        if (ex_fwd_en && ex_fwd_rt == r) return ex_fwd_res;
        if (wb_en && wb_rt == r) return wb_res;
        return m_regs[r];
    endfunction

    // Reference immediate as signed arithmetic: prefix * 2^25 + low field
    function automatic logic [63:0] ref_imm(input logic [41:0] ir);
        logic signed [24:0] s25;
        logic signed [34:0] s35;
        logic signed [63:0] v;
        logic signed [63:0] p;
        s25 = ir[24:0];
        s35 = m_pfx;
        if (m_pfx_v) begin
            p = s35;
            v = (p <<< 25) + {39'd0, ir[24:0]};
        end else begin
            v = s25;
        end
        return v;
    endfunction

    // Reference model: evaluated once per cycle on the inputs about to be clocked
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            begin
                bit    rdy;
                bund_t e;
                rdy = !m_xvalid || x_ready;
                if (!rst_ni) begin
                    m_xvalid = 0; m_pfx_v = 0; m_zero = 1; expq.delete();
                end else if (flush) begin
                    m_xvalid = 0; m_pfx_v = 0; expq.delete();
                end else begin
                    if (m_xvalid && x_ready) m_xvalid = 0;
                    if (d_valid && rdy) begin
                        if (d_ir[41:35] == OP_IMM) begin
                            m_pfx_v = 1;
                            m_pfx   = d_ir[34:0];
                        end else begin
                            e.ir  = d_ir;
                            e.a   = ref_opnd(d_ir[34:30]);
                            e.b   = ref_opnd(d_ir[29:25]);
                            e.imm = ref_imm(d_ir);
                            expq.push_back(e);
                            m_xvalid = 1; m_pfx_v = 0; m_zero = 0;
                        end
                    end
                end
                if (wb_en && wb_rt != 0) m_regs[wb_rt] = wb_res;
            end
        end
    end

    // Monitor: checks handshake state every cycle, pops on each consumed bundle
    initial begin
        forever begin
            @(negedge clk_i);
            chk("x_valid", 64'(x_valid), 64'(m_xvalid));
            chk("d_ready", 64'(d_ready), 64'(!m_xvalid || x_ready));
            if (m_zero) begin
                chk("rst_xIR", 64'(xIR), 64'd0);
                chk("rst_a", a, 64'd0);
                chk("rst_b", b, 64'd0);
                chk("rst_imm", imm, 64'd0);
            end
            if (x_valid && x_ready && rst_ni && !flush) begin
                if (expq.size() == 0) begin
                    chk("unexpected_bundle", 64'(xIR), 64'd0);
                end else begin
                    bund_t e;
                    e = expq.pop_front();
                    chk("bundle_ir", 64'(xIR), 64'(e.ir));
                    chk("bundle_a", a, e.a);
                    chk("bundle_b", b, e.b);
                    chk("bundle_imm", imm, e.imm);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rst_ni = 1; d_valid = 0; d_ir = '0; flush = 0; x_ready = 1;
        ex_fwd_en = 0; ex_fwd_rt = '0; ex_fwd_res = '0;
        wb_en = 0; wb_rt = '0; wb_res = '0;
    endtask

    initial begin
        idle();
        rst_ni = 0;
        step(); step();
        chk("reset_x_valid", 64'(x_valid), 64'd0);
        chk("reset_imm", imm, 64'd0);
        rst_ni = 1;

        // Give every register a known value
        for (int r = 1; r < 32; r++) begin
            wb_en = 1; wb_rt = 5'(r); wb_res = {$urandom, $urandom};
            step();
        end
        idle();

        // Register read through the file
        wb_en = 1; wb_rt = 5'd3; wb_res = 64'h1234; step();
        idle(); d_valid = 1; d_ir = mk(OP_ORI, 5'd3, 5'd0, 25'h0000F); step();
        idle();
        chk("ori_valid", 64'(x_valid), 64'd1);
        chk("ori_a", a, 64'h1234);
        chk("ori_imm", imm, 64'hF);

        // Execute bypass beats writeback bypass
        d_valid = 1; d_ir = mk(OP_RR, 5'd5, 5'd5, {18'd0, FN_AND});
        ex_fwd_en = 1; ex_fwd_rt = 5'd5; ex_fwd_res = 64'hAAAA;
        wb_en = 1; wb_rt = 5'd5; wb_res = 64'h5555;
        step(); idle();
        chk("bypass_a", a, 64'hAAAA);
        chk("bypass_b", b, 64'hAAAA);

        // Prefix extension, then plain sign extension
        d_valid = 1; d_ir = {OP_IMM, 35'h400000001}; step();
        chk("imm_no_bundle", 64'(x_valid), 64'd0);
        d_ir = mk(OP_XORI, 5'd1, 5'd2, 25'h1FFFFFF); step();
        chk("pfx_imm", imm, 64'hF800_0000_03FF_FFFF);
        step(); idle();
        chk("sext_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        // Stall: bundle frozen, operand not refreshed by a writeback
        wb_en = 1; wb_rt = 5'd7; wb_res = 64'h7777; step(); idle();
        d_valid = 1; d_ir = mk(OP_ANDI, 5'd7, 5'd0, 25'h1); step();
        x_ready = 0; d_ir = mk(OP_ORI, 5'd7, 5'd0, 25'h2);
        wb_en = 1; wb_rt = 5'd7; wb_res = 64'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_d_ready", 64'(d_ready), 64'd0);
            chk("stall_a", a, 64'h7777);
        end
        wb_en = 0; x_ready = 1; step();
        chk("after_stall_a", a, 64'hBEEF);
        idle(); step();

        // Flush clears a pending prefix and discards a same-cycle transfer
        d_valid = 1; d_ir = {OP_IMM, 35'h7_1234_5678}; step();
        flush = 1; d_ir = mk(OP_ORI, 5'd1, 5'd0, 25'h3); step();
        chk("flush_x_valid", 64'(x_valid), 64'd0);
        flush = 0; d_ir = mk(OP_ANDI, 5'd1, 5'd0, 25'h10); step();
        idle();
        chk("flush_imm", imm, 64'h10);

        // r0 is never written and never bypassed
        wb_en = 1; wb_rt = 5'd0; wb_res = 64'hFFFF; step(); idle();
        d_valid = 1; d_ir = mk(OP_ORI, 5'd0, 5'd0, 25'h0); step();
        chk("r0_read", a, 64'd0);
        wb_en = 1; wb_rt = 5'd0; wb_res = 64'hFFFF;
        ex_fwd_en = 1; ex_fwd_rt = 5'd0; ex_fwd_res = 64'h1;
        step(); idle();
        chk("r0_bypass", a, 64'd0);

        // Reset with a live bundle, then reset with a pending prefix
        d_valid = 1; d_ir = mk(OP_ANDI, 5'd3, 5'd4, 25'h55); step(); idle();
        rst_ni = 0; step();
        chk("rst_live_valid", 64'(x_valid), 64'd0);
        chk("rst_live_a", a, 64'd0);
        rst_ni = 1; d_valid = 1; d_ir = {OP_IMM, 35'h5_5555_5555}; step();
        idle(); rst_ni = 0; step();
        rst_ni = 1; d_valid = 1; d_ir = mk(OP_ANDI, 5'd0, 5'd0, 25'h10); step();
        idle();
        chk("rst_pfx_imm", imm, 64'h10);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 5))
                0: opc = OP_RR;   1: opc = OP_ADDI; 2: opc = OP_ANDI;
                3: opc = OP_ORI;  4: opc = OP_XORI; default: opc = OP_IMM;
            endcase
            rst_ni     = ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            d_valid    = ($urandom_range(0, 9) < 7);
            d_ir       = {opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 25'($urandom)};
            if (opc == OP_IMM) d_ir[34:0] = {3'($urandom), 32'($urandom)};
            x_ready    = ($urandom_range(0, 9) < 7);
            ex_fwd_en  = ($urandom_range(0, 9) < 4);
            ex_fwd_rt  = 5'($urandom_range(0, 7));
            ex_fwd_res = {$urandom, $urandom};
            wb_en      = ($urandom_range(0, 9) < 5);
            wb_rt      = 5'($urandom_range(0, 7));
            wb_res     = {$urandom, $urandom};
            step();
        end

        idle();
        repeat (4) step();
        chk("drain_queue", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
